// File: rtl/weight_ser_tx_pkg.sv
// Shared constants, FSM encoding and word-count clamp for the weight serial transmitter.
// Optional build macro: WEIGHT_TX_PARITY_EN (adds one even-parity slot per word).
package weight_ser_tx_pkg;
  localparam int WORD_W    = 16;
  localparam int MAX_WORDS = 12;
  localparam int ADDR_W    = 4;
  localparam int CNT_W     = 5;

`ifdef WEIGHT_TX_PARITY_EN
  localparam int SLOT_L = WORD_W + 1;
`else
  localparam int SLOT_L = WORD_W;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SHIFT = 2'd3
  } tx_state_t;

  function automatic logic [ADDR_W-1:0] clamp_words(input logic [ADDR_W-1:0] nw);
    return (nw > ADDR_W'(MAX_WORDS)) ? ADDR_W'(MAX_WORDS) : nw;
  endfunction
endpackage

// File: rtl/weight_ser_tx_if.sv
// Control, register-file read and serial output signals of weight_ser_tx.
// slave = transmitter side, master = controller / register file / pin side.
interface weight_ser_tx_if import weight_ser_tx_pkg::*; ();
  logic              start;
  logic [ADDR_W-1:0] num_words;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic              ser_out;
  logic              ser_valid;
  logic              busy;
  logic              done;

  modport slave (
    input  start, num_words, rd_data,
    output rd_en, rd_addr, ser_out, ser_valid, busy, done
  );

  modport master (
    output start, num_words, rd_data,
    input  rd_en, rd_addr, ser_out, ser_valid, busy, done
  );
endinterface

// File: rtl/weight_ser_tx_piso_shift.sv
// Parallel-load, right-shift register; lsb is the next bit to be placed on the line.
module piso_shift import weight_ser_tx_pkg::*; (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  output logic              lsb
);
  logic [WORD_W-1:0] r_sr;

  always_ff @(posedge CLK) begin
    if (!RST)       r_sr <= '0;
    else if (load)  r_sr <= din;
    else if (shift) r_sr <= {1'b0, r_sr[WORD_W-1:1]};
  end

  assign lsb = r_sr[0];
endmodule

// File: rtl/weight_ser_tx.sv
// Serialises trained weight words LSB first, highest address first, no gap between words.
// Optional build macro: WEIGHT_TX_PARITY_EN (even-parity bit after each word).
module weight_ser_tx import weight_ser_tx_pkg::*; (
  input  logic            CLK,
  input  logic            RST,
  weight_ser_tx_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_PREF = CNT_W'(SLOT_L - 3);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_L - 1);

  tx_state_t         r_state;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_ser_out;
  logic              r_ser_valid;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_pref;
`ifdef WEIGHT_TX_PARITY_EN
  logic              r_par;
`endif

  logic [ADDR_W-1:0] w_n;
  logic              w_last;
  logic              w_load;
  logic              w_shift;
  logic              w_lsb;
  logic [WORD_W-1:0] w_din;

  assign w_n    = clamp_words(bus.num_words);
  assign w_last = (r_bit_cnt == CNT_LAST);
  // bit0 goes straight to the line on load, so the shifter only holds the rest
  assign w_din   = {1'b0, bus.rd_data[WORD_W-1:1]};
  assign w_load  = (r_state == ST_LOAD) || ((r_state == ST_SHIFT) && w_last && r_pref);
  assign w_shift = (r_state == ST_SHIFT) && !w_last;

  piso_shift u_piso (
    .CLK   (CLK),
    .RST   (RST),
    .load  (w_load),
    .shift (w_shift),
    .din   (w_din),
    .lsb   (w_lsb)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bit_cnt   <= '0;
      r_pref      <= 1'b0;
`ifdef WEIGHT_TX_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          // a start coinciding with done is dropped, not deferred
          if (bus.start && !r_done) begin
            if (w_n == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy    <= 1'b1;
              r_rd_en   <= 1'b1;
              r_rd_addr <= w_n - ADDR_W'(1);
              r_state   <= ST_PRIME;
            end
          end
        end
        ST_PRIME: r_state <= ST_LOAD;
        ST_LOAD: begin
          r_ser_out   <= bus.rd_data[0];
          r_ser_valid <= 1'b1;
          r_bit_cnt   <= '0;
          r_pref      <= 1'b0;
`ifdef WEIGHT_TX_PARITY_EN
          r_par       <= ^bus.rd_data;
`endif
          r_state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          // fetch the next word early enough that it lands exactly on the word boundary
          if (r_bit_cnt == CNT_PREF && r_rd_addr != '0) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_rd_addr - ADDR_W'(1);
            r_pref    <= 1'b1;
          end
          if (w_last) begin
            r_bit_cnt <= '0;
            if (r_pref) begin
              r_ser_out <= bus.rd_data[0];
              r_pref    <= 1'b0;
`ifdef WEIGHT_TX_PARITY_EN
              r_par     <= ^bus.rd_data;
`endif
            end else begin
              r_ser_out   <= 1'b0;
              r_ser_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
`ifdef WEIGHT_TX_PARITY_EN
          else if (r_bit_cnt == CNT_W'(WORD_W - 1)) begin
            r_ser_out <= r_par;
          end
`endif
          else begin
            r_ser_out <= w_lsb;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.ser_out   = r_ser_out;
  assign bus.ser_valid = r_ser_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule
